mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu_pkg.sv | 19 +
 rtl/mc_alu_if.sv | 27 ++
 rtl/mc_alu_mul.sv | 48 ++++
 rtl/mc_alu.sv | 120 ++++++++++++
 tb/tb_mc_alu.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mc_alu_pkg.sv
// Shared opcode constants and FSM state type for mc_alu.
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mc_alu_if.sv
// Request/response bus of mc_alu: valid/ready in, valid/ready out.
interface mc_alu_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [2:0]       select;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             carry;
    logic             error;

    modport master (
        output in_valid, data1, data2, select, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, carry, error
    );

    modport slave (
        input  in_valid, data1, data2, select, out_ready,
        output in_ready, out_valid, result, result_hi, zero, carry, error
    );

endinterface

// File: rtl/mc_alu_mul.sv
// Shift-add unsigned multiplier: first step on start, then one step per cycle,
// WIDTH steps total; done pulses for one cycle once the product is final.
module mc_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;

    // Upper half accumulates, lower half holds the remaining multiplier bits.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {s, p[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand   <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= a;
                product <= step({{WIDTH{1'b0}}, b}, a);
                cnt     <= CW'(WIDTH - 1);
            end else if (cnt != '0) begin
                product <= step(product, mcand);
                cnt     <= cnt - 1'b1;
                done    <= (cnt == CW'(1));
            end
        end
    end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU with valid/ready handshake; multiplier built only when
// MC_ALU_MUL_EN is defined, otherwise opcode 111 completes with ERROR=1.
module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   resetn,
    mc_alu_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 32 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("mc_alu: WIDTH must be a power of two in 4..32");
    end

    state_t           state;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   wide;
    logic             alu_c;
    logic             alu_e;
    logic [SHW-1:0]   shamt;

    assign bus.in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
    assign bus.out_valid = (state == ST_DONE);
    assign accept        = bus.in_valid & bus.in_ready;
    assign shamt         = bus.data2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_e   = 1'b0;
        wide    = '0;
        case (bus.select)
            OP_FWD: alu_res = bus.data2;
            OP_ADD: begin
                wide    = {1'b0, bus.data1} + {1'b0, bus.data2};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_AND: alu_res = bus.data1 & bus.data2;
            OP_OR:  alu_res = bus.data1 | bus.data2;
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow.
                wide    = {1'b0, bus.data1} - {1'b0, bus.data2};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_SLL: alu_res = bus.data1 << shamt;
            OP_SRA: alu_res = $signed(bus.data1) >>> shamt;
            OP_MUL: begin
`ifndef MC_ALU_MUL_EN
                alu_e = 1'b1;
`endif
            end
            default: ;
        endcase
    end

`ifdef MC_ALU_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign mul_start = accept & (bus.select == OP_MUL);

    mc_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .resetn  (resetn),
        .start   (mul_start),
        .a       (bus.data1),
        .b       (bus.data2),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.zero      <= 1'b0;
            bus.carry     <= 1'b0;
            bus.error     <= 1'b0;
        end else if (accept) begin
`ifdef MC_ALU_MUL_EN
            if (bus.select == OP_MUL) state <= ST_BUSY;
            else
`endif
            begin
                state         <= ST_DONE;
                bus.result    <= alu_res;
                bus.result_hi <= '0;
                bus.zero      <= (alu_res == '0);
                bus.carry     <= alu_c;
                bus.error     <= alu_e;
            end
        end else begin
            case (state)
`ifdef MC_ALU_MUL_EN
                ST_BUSY: if (mul_done) begin
                    state         <= ST_DONE;
                    bus.result    <= mul_prod[WIDTH-1:0];
                    bus.result_hi <= mul_prod[2*WIDTH-1:WIDTH];
                    bus.zero      <= (mul_prod == '0);
                    bus.carry     <= 1'b0;
                    bus.error     <= 1'b0;
                end
`endif
                ST_DONE: if (bus.out_ready) state <= ST_IDLE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Directed scoreboard bench for mc_alu (WIDTH=8); follows MC_ALU_MUL_EN.
module tb_mc_alu;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    mc_alu_if #(.WIDTH(8)) bus();

    mc_alu #(.WIDTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic       z;
        logic       c;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [15:0] w;
        logic [7:0]  r;
        int          sh;
        e  = '{res: 8'h0, hi: 8'h0, z: 1'b0, c: 1'b0, e: 1'b0};
        sh = int'(b[2:0]);
        case (op)
            3'd0: e.res = b;
            3'd1: begin w = 16'(a) + 16'(b); e.res = w[7:0]; e.c = w[8]; end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: begin e.res = a - b; e.c = (a < b); end
            3'd5: begin w = 16'(a) << sh; e.res = w[7:0]; end
            3'd6: begin
                r = a;
                for (int i = 0; i < sh; i++) r = {r[7], r[7:1]};
                e.res = r;
            end
            default: begin
`ifdef MC_ALU_MUL_EN
                w = 16'(a) * 16'(b);
                e.res = w[7:0];
                e.hi  = w[15:8];
`else
                e.e = 1'b1;
`endif
            end
        endcase
        e.z = (e.res == 8'h0) && (e.hi == 8'h0);
        return e;
    endfunction

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(bus.out_valid), 1);
        chk({tag, ".res"},   32'(bus.result),    32'(e.res));
        chk({tag, ".hi"},    32'(bus.result_hi), 32'(e.hi));
        chk({tag, ".zero"},  32'(bus.zero),      32'(e.z));
        chk({tag, ".carry"}, 32'(bus.carry),     32'(e.c));
        chk({tag, ".err"},   32'(bus.error),     32'(e.e));
    endtask

    // Called and returns just after a falling edge, with out_ready=1.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   n, nbusy, lat;
        lat = 1;
`ifdef MC_ALU_MUL_EN
        if (op == 3'b111) lat = 9;
`endif
        sb.push_back(model(op, a, b));
        bus.select   = op;
        bus.data1    = a;
        bus.data2    = b;
        bus.in_valid = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.data1    = 8'($urandom);
        bus.data2    = 8'($urandom);
        bus.select   = 3'($urandom);
        n = 1;
        nbusy = 0;
        while (!bus.out_valid && n < 40) begin
            if (!bus.in_ready) nbusy++;
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, n, lat);
        chk({tag, ".busy_cycles"}, nbusy, lat - 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_out(tag, e);
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.data1     = '0;
        bus.data2     = '0;
        bus.select    = '0;
        repeat (2) @(negedge clk);
        chk("rst.valid", 32'(bus.out_valid), 0);
        chk("rst.res",   32'(bus.result),    0);
        chk("rst.hi",    32'(bus.result_hi), 0);
        chk("rst.flags", 32'({bus.zero, bus.carry, bus.error}), 0);
        resetn = 1'b1;
        #1;
        chk("rst.in_ready", 32'(bus.in_ready), 1);

        run_op("add_f0_20", 3'b001, 8'hF0, 8'h20);
        run_op("sub_eq",    3'b100, 8'h05, 8'h05);
        run_op("sra_80_0b", 3'b110, 8'h80, 8'h0B);
        run_op("sub_borrow",3'b100, 8'h05, 8'h06);
        run_op("sll_81_0f", 3'b101, 8'h81, 8'h0F);
        run_op("sra_pos",   3'b110, 8'h70, 8'h02);
        run_op("add_wrap",  3'b001, 8'hFF, 8'h01);
        run_op("and",       3'b010, 8'hA5, 8'h0F);
        run_op("fwd_aa",    3'b000, 8'h11, 8'hAA);
        run_op("mul_ff_ff", 3'b111, 8'hFF, 8'hFF);
        run_op("mul_0d_0b", 3'b111, 8'h0D, 8'h0B);
        run_op("mul_zero",  3'b111, 8'h00, 8'h9C);

        // Back-pressure, then back-to-back accept from DONE.
        sb.push_back(model(3'b011, 8'h0C, 8'h03));
        bus.out_ready = 1'b0;
        bus.select = 3'b011; bus.data1 = 8'h0C; bus.data2 = 8'h03; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("bp%0d", i), e);
            chk($sformatf("bp%0d.in_ready", i), 32'(bus.in_ready), 0);
            @(negedge clk);
        end
        sb.push_back(model(3'b010, 8'hFF, 8'h3C));
        bus.out_ready = 1'b1;
        bus.select = 3'b010; bus.data1 = 8'hFF; bus.data2 = 8'h3C; bus.in_valid = 1'b1;
        #1;
        chk("b2b.in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        chk_out("b2b", e);
        @(negedge clk);

        // Asynchronous reset while holding a result in DONE.
        bus.out_ready = 1'b0;
        bus.select = 3'b000; bus.data2 = 8'hA5; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("hold.res", 32'(bus.result), 32'h0A5);
        resetn = 1'b0;
        #1;
        chk("rst_done.valid", 32'(bus.out_valid), 0);
        chk("rst_done.res",   32'(bus.result),    0);
        @(negedge clk);
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_done.in_ready", 32'(bus.in_ready), 1);
        run_op("fwd_55", 3'b000, 8'h00, 8'h55);

`ifdef MC_ALU_MUL_EN
        // Reset in the middle of a multiply.
        bus.select = 3'b111; bus.data1 = 8'h37; bus.data2 = 8'h5A; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midmul.busy", 32'(bus.in_ready), 0);
        resetn = 1'b0;
        #1;
        chk("midmul.valid", 32'(bus.out_valid), 0);
        chk("midmul.res",   32'(bus.result),    0);
        chk("midmul.hi",    32'(bus.result_hi), 0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("midmul.in_ready", 32'(bus.in_ready), 1);
        run_op("fwd_55_post", 3'b000, 8'h00, 8'h55);
        run_op("mul_post",    3'b111, 8'h37, 8'h5A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
